dht11_responder: RTL and testbench

Synthesizable sensor-side responder for the DHT11 single-wire protocol; it is the other end of the link that SensorDecoder drives as host. It watches the open-drain transmission line for a host start pulse. It then answers with the ACK preamble and a 40-bit frame carrying caller-supplied humidity and temperature bytes plus checksum. It serves as an on-FPGA sensor stand-in for bring-up and loopback tests of the DigitalSensor request path.

---
 rtl/dht11_responder.sv | 184 ++++++++++++++++++
 tb/tb_dht11_responder.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/dht11_responder.sv
// dht11_responder: sensor-side end of the DHT11 single-wire link.
// It waits for a long host low pulse, then answers with the ACK preamble
// and a 40-bit humidity/temperature frame, MSB first, checksum last.
// Line valid/ready note: there is no handshake here; the host owns the
// start pulse, and the responder owns the line from acceptance until
// END_LOW finishes. Line activity in that window is ignored.
module dht11_responder #(
   parameter int CLOCKS_PER_US = 50,
   parameter int START_MIN_US  = 18000,
   parameter int RESP_DELAY_US = 30
) (
   input  logic       clock,
   input  logic       reset_n,
   inout  wire        transmission_line,
   input  logic [7:0] humidity_int,
   input  logic [7:0] humidity_dec,
   input  logic [7:0] temperature_int,
   input  logic [7:0] temperature_dec,
   input  logic       corrupt_checksum,
   output logic       busy,
   output logic       frame_done
);

   localparam int START_TICKS   = START_MIN_US * CLOCKS_PER_US;
   localparam int RESP_TICKS    = RESP_DELAY_US * CLOCKS_PER_US;
   localparam int ACK_TICKS     = 80 * CLOCKS_PER_US;
   localparam int BIT_LOW_TICKS = 50 * CLOCKS_PER_US;
   localparam int ZERO_TICKS    = 26 * CLOCKS_PER_US;
   localparam int ONE_TICKS     = 70 * CLOCKS_PER_US;
   localparam int END_TICKS     = 50 * CLOCKS_PER_US;

   // ACK is the longest fixed phase; start and response delay are tunable.
   localparam int MAX_A     = (START_TICKS > RESP_TICKS) ? START_TICKS : RESP_TICKS;
   localparam int MAX_TICKS = (MAX_A > ACK_TICKS) ? MAX_A : ACK_TICKS;
   localparam int CNT_W     = $clog2(MAX_TICKS + 1);

   localparam logic [CNT_W-1:0] START_SAT    = CNT_W'(START_TICKS);
   // The IDLE cycle that first sees the line low counts as the first low
   // cycle, so START_LOW only needs to accumulate threshold-1 more.
   localparam logic [CNT_W-1:0] START_LAST   = CNT_W'(START_TICKS - 1);
   localparam logic [CNT_W-1:0] RESP_LAST    = CNT_W'(RESP_TICKS - 1);
   localparam logic [CNT_W-1:0] ACK_LAST     = CNT_W'(ACK_TICKS - 1);
   localparam logic [CNT_W-1:0] BIT_LOW_LAST = CNT_W'(BIT_LOW_TICKS - 1);
   localparam logic [CNT_W-1:0] ZERO_LAST    = CNT_W'(ZERO_TICKS - 1);
   localparam logic [CNT_W-1:0] ONE_LAST     = CNT_W'(ONE_TICKS - 1);
   localparam logic [CNT_W-1:0] END_LAST     = CNT_W'(END_TICKS - 1);
   localparam logic [5:0]       LAST_BIT     = 6'd39;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START_LOW = 3'd1,
      WAIT_RESP = 3'd2,
      ACK_LOW   = 3'd3,
      ACK_HIGH  = 3'd4,
      BIT_LOW   = 3'd5,
      BIT_HIGH  = 3'd6,
      END_LOW   = 3'd7
   } state_t;

   state_t            state_q, state_d;
   logic              line_meta, line_s;
   logic [CNT_W-1:0]  cnt_q;
   logic [5:0]        bit_cnt_q;
   logic [39:0]       shift_q;
   logic              drive_low;
   logic              load_frame;
   logic              shift_en;
   logic [9:0]        sum10;
   logic [7:0]        checksum;
   logic [CNT_W-1:0]  high_last;

   // Open-drain pad: pull low or float, never drive high.
   assign transmission_line = drive_low ? 1'b0 : 1'bz;

   // Payload checksum, widened so the carry is visible before truncation.
   assign sum10    = {2'b00, humidity_int} + {2'b00, humidity_dec}
                   + {2'b00, temperature_int} + {2'b00, temperature_dec};
   assign checksum = sum10[7:0] ^ {8{corrupt_checksum}};

   // Bit-high duration is chosen by the bit currently at the MSB.
   assign high_last = shift_q[39] ? ONE_LAST : ZERO_LAST;

   // Two-flop synchronizer; resets to the released (pulled-up) level.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         line_meta <= 1'b1;
         line_s    <= 1'b1;
      end else begin
         line_meta <= transmission_line;
         line_s    <= line_meta;
      end
   end

   // Next-state decode and per-phase strobes.
   always_comb begin
      state_d    = state_q;
      load_frame = 1'b0;
      shift_en   = 1'b0;
      frame_done = 1'b0;
      case (state_q)
         IDLE: begin
            if (!line_s) state_d = START_LOW;
         end
         START_LOW: begin
            if (line_s) begin
               if (cnt_q >= START_LAST) begin
                  state_d    = WAIT_RESP;
                  load_frame = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         WAIT_RESP: begin
            if (cnt_q == RESP_LAST) state_d = ACK_LOW;
         end
         ACK_LOW: begin
            if (cnt_q == ACK_LAST) state_d = ACK_HIGH;
         end
         ACK_HIGH: begin
            if (cnt_q == ACK_LAST) state_d = BIT_LOW;
         end
         BIT_LOW: begin
            if (cnt_q == BIT_LOW_LAST) state_d = BIT_HIGH;
         end
         BIT_HIGH: begin
            if (cnt_q == high_last) begin
               shift_en = 1'b1;
               state_d  = (bit_cnt_q == LAST_BIT) ? END_LOW : BIT_LOW;
            end
         end
         END_LOW: begin
            if (cnt_q == END_LAST) begin
               frame_done = 1'b1;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy = (state_q != IDLE) && (state_q != START_LOW);

   // State register plus the registered line drive for the next state.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         drive_low <= 1'b0;
      end else begin
         state_q   <= state_d;
         drive_low <= (state_d == ACK_LOW) || (state_d == BIT_LOW) || (state_d == END_LOW);
      end
   end

   // Phase counter: cleared on every state entry, saturates in START_LOW.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else if (state_d != state_q) begin
         cnt_q <= '0;
      end else if (state_q == IDLE) begin
         cnt_q <= '0;
      end else if (state_q == START_LOW) begin
         if (cnt_q != START_SAT) cnt_q <= cnt_q + 1'b1;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   // Frame shift register and bit index; payload frozen at acceptance.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         shift_q   <= '0;
         bit_cnt_q <= '0;
      end else if (load_frame) begin
         shift_q   <= {humidity_int, humidity_dec, temperature_int, temperature_dec, checksum};
         bit_cnt_q <= '0;
      end else if (shift_en) begin
         shift_q   <= {shift_q[38:0], 1'b0};
         bit_cnt_q <= (bit_cnt_q == LAST_BIT) ? 6'd0 : bit_cnt_q + 1'b1;
      end
   end

endmodule

// File: tb/tb_dht11_responder.sv
// tb_dht11_responder: directed bench for the DHT11 sensor-side responder.
// Scaled timing: 2 clocks/us, 40 us start threshold, 30 us response gap.
module tb_dht11_responder;

   localparam int CPU        = 2;
   localparam int START_US   = 40;
   localparam int RESP_US    = 30;
   localparam int START_T    = START_US * CPU;   // 80
   localparam int RESP_T     = RESP_US * CPU;    // 60
   localparam int ACK_T      = 80 * CPU;         // 160
   localparam int BLOW_T     = 50 * CPU;         // 100
   localparam int ZERO_T     = 26 * CPU;         // 52
   localparam int ONE_T      = 70 * CPU;         // 140
   localparam int END_T      = 50 * CPU;         // 100
   localparam int RUN_LIMIT  = 200;
   // Release at posedge+1 reaches line_s two edges later, WAIT_RESP one
   // edge after that, then RESP_T cycles of gap before the pad goes low.
   localparam int REL_TO_ACK = RESP_T + 3;

   logic       clock;
   logic       reset_n;
   logic       host_low;
   logic [7:0] h_int, h_dec, t_int, t_dec;
   logic       corrupt;
   logic       busy;
   logic       frame_done;
   wire        line;
   logic       obs;

   int tests;
   int fails;
   int done_cnt;
   logic done_line;
   logic stuck;

   assign line = host_low ? 1'b0 : 1'bz;
   pullup (line);

   // While the host holds the line, the responder's own drive is observed.
   assign obs = host_low ? ~dut.drive_low : line;

   dht11_responder #(
      .CLOCKS_PER_US (CPU),
      .START_MIN_US  (START_US),
      .RESP_DELAY_US (RESP_US)
   ) dut (
      .clock             (clock),
      .reset_n           (reset_n),
      .transmission_line (line),
      .humidity_int      (h_int),
      .humidity_dec      (h_dec),
      .temperature_int   (t_int),
      .temperature_dec   (t_dec),
      .corrupt_checksum  (corrupt),
      .busy              (busy),
      .frame_done        (frame_done)
   );

   // Clock.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // frame_done monitor.
   always @(negedge clock) begin
      if (frame_done === 1'b1) begin
         done_cnt  = done_cnt + 1;
         done_line = obs;
      end
   end

   task automatic check(input logic [63:0] got, input logic [63:0] exp, input string tag);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic set_payload(input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] c, input logic [7:0] d, input logic cc);
      h_int = a; h_dec = b; t_int = c; t_dec = d; corrupt = cc;
   endtask

   // Host start pulse: low for exactly n clock cycles, ends at posedge+1.
   task automatic host_start(input int n);
      @(posedge clock); #1 host_low = 1'b1;
      repeat (n) @(posedge clock);
      #1 host_low = 1'b0;
   endtask

   // Length of the run of samples at 'level', starting at the current negedge.
   task automatic measure(input logic level, output int len);
      len = 0;
      if (stuck) return;
      while (obs === level && len < RUN_LIMIT) begin
         len++;
         @(negedge clock);
      end
      if (len == RUN_LIMIT) begin
         stuck = 1'b1;
         check(64'(len), 64'(RUN_LIMIT - 1), "run_bound");
      end
   endtask

   // Receive one full response after a host release and check its timing.
   task automatic rx_frame(input logic [39:0] exp, input string tag);
      int len;
      int bad_low;
      int bad_high;
      int d0;
      logic [39:0] data;
      d0       = done_cnt;
      data     = '0;
      bad_low  = 0;
      bad_high = 0;
      @(negedge clock);
      measure(1'b1, len); check(64'(len), 64'(REL_TO_ACK), {tag, "_resp_gap"});
      check(64'(busy), 64'd1, {tag, "_busy_hi"});
      measure(1'b0, len); check(64'(len), 64'(ACK_T), {tag, "_ack_low"});
      measure(1'b1, len); check(64'(len), 64'(ACK_T), {tag, "_ack_high"});
      for (int i = 0; i < 40; i++) begin
         measure(1'b0, len);
         if (len != BLOW_T) bad_low++;
         measure(1'b1, len);
         if (len != ZERO_T && len != ONE_T) bad_high++;
         data = {data[38:0], (len > (ZERO_T + ONE_T) / 2)};
      end
      check(64'(bad_low), 64'd0, {tag, "_bit_low_len"});
      check(64'(bad_high), 64'd0, {tag, "_bit_high_len"});
      check(64'(data), 64'(exp), {tag, "_data"});
      measure(1'b0, len); check(64'(len), 64'(END_T), {tag, "_end_low"});
      check(64'(done_cnt - d0), 64'd1, {tag, "_done_once"});
      check(64'(done_line), 64'd0, {tag, "_done_in_end_low"});
      check(64'(busy), 64'd0, {tag, "_busy_lo"});
      repeat (5) @(negedge clock);
      check(64'(line), 64'd1, {tag, "_released"});
   endtask

   initial begin
      logic drove;
      logic was_busy;
      int d0;
      tests     = 0;
      fails     = 0;
      done_cnt  = 0;
      done_line = 1'b1;
      stuck     = 1'b0;
      host_low  = 1'b0;
      reset_n   = 1'b0;
      set_payload(8'h00, 8'h00, 8'h00, 8'h00, 1'b0);

      // Reset state.
      repeat (3) @(posedge clock);
      #1;
      check(64'(line), 64'd1, "rst_line");
      check(64'(busy), 64'd0, "rst_busy");
      check(64'(frame_done), 64'd0, "rst_done");
      reset_n = 1'b1;
      repeat (5) @(posedge clock);

      // Valid start exactly at threshold.
      set_payload(8'h37, 8'h00, 8'h19, 8'h05, 1'b0);
      host_start(START_T);
      rx_frame(40'h37_00_19_05_55, "valid");

      // Start one cycle short: never answered.
      d0 = done_cnt;
      drove = 1'b0;
      was_busy = 1'b0;
      host_start(START_T - 1);
      repeat (400) begin
         @(negedge clock);
         if (line !== 1'b1) drove = 1'b1;
         if (busy !== 1'b0) was_busy = 1'b1;
      end
      check(64'(drove), 64'd0, "short_line");
      check(64'(was_busy), 64'd0, "short_busy");
      check(64'(done_cnt - d0), 64'd0, "short_done");

      // Checksum wrap and forced corruption.
      set_payload(8'hFF, 8'hFF, 8'h01, 8'h02, 1'b0);
      host_start(START_T + 7);
      rx_frame(40'hFF_FF_01_02_01, "wrap");
      set_payload(8'hFF, 8'hFF, 8'h01, 8'h02, 1'b1);
      host_start(START_T);
      rx_frame(40'hFF_FF_01_02_FE, "corrupt");

      // Payload change during BIT_LOW of bit 3 (839..938 cycles after release).
      set_payload(8'h12, 8'h34, 8'h56, 8'h78, 1'b0);
      host_start(START_T);
      fork
         rx_frame(40'h12_34_56_78_14, "frozen");
         begin
            repeat (889) @(posedge clock);
            #1 set_payload(8'hAA, 8'hAA, 8'hAA, 8'hAA, 1'b1);
         end
      join

      // Host pulls low during ACK_HIGH (223..382 cycles after release).
      set_payload(8'hA5, 8'h5A, 8'hC3, 8'h3C, 1'b0);
      host_start(START_T);
      fork
         rx_frame(40'hA5_5A_C3_3C_FE, "interfere");
         begin
            repeat (REL_TO_ACK + ACK_T + 20) @(posedge clock);
            #1 host_low = 1'b1;
            repeat (40) @(posedge clock);
            #1 host_low = 1'b0;
         end
      join

      // Reset during bit 20 low (bit 20 starts 3951 cycles after release).
      set_payload(8'h37, 8'h00, 8'h19, 8'h05, 1'b0);
      host_start(START_T);
      repeat (3981) @(posedge clock);
      #2;
      check(64'(line), 64'd0, "pre_reset_low");
      reset_n = 1'b0;
      #1;
      check(64'(line), 64'd1, "reset_release");
      check(64'(busy), 64'd0, "reset_busy");
      @(posedge clock); #1 reset_n = 1'b1;
      repeat (5) @(posedge clock);
      host_start(START_T);
      rx_frame(40'h37_00_19_05_55, "after_reset");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
